// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register between decode and execute.
// Carries the decoded instruction across a valid/ready boundary. While an
// instruction is held, it also refreshes its register operands from the
// writeback port.
// Optional build macro ID_EX_SKID_EN adds a skid entry behind the output
// entry, so that in_ready is a flop and does not depend combinationally
// on out_ready.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_valid/in_* and out_valid/out_* are held by their producer
// until that transfer. flush beats every other transfer in its cycle.

package riscv_pkg;
  parameter int XLEN           = 32;
  parameter int REG_ADDR_WIDTH = 5;
endpackage

module id_ex_pipe
  import riscv_pkg::*;
#(
  parameter int CTRL_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [XLEN-1:0]           in_rs1_data,
  input  logic [XLEN-1:0]           in_rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_rd_wen,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic                      flush,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_imm,
  output logic [XLEN-1:0]           out_rs1_data,
  output logic [XLEN-1:0]           out_rs2_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_rd_wen,
  output logic [CTRL_W-1:0]         out_ctrl
);

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           imm;
    logic [XLEN-1:0]           rs1_data;
    logic [XLEN-1:0]           rs2_data;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      rd_wen;
    logic [CTRL_W-1:0]         ctrl;
  } entry_t;

  entry_t in_entry;
  entry_t out_q;
  logic   out_valid_q;
  logic   accept;
  logic   wb_hit;

  // x0 is never written, so a write enable aimed at it is dropped here.
  always_comb begin
    in_entry          = '0;
    in_entry.pc       = in_pc;
    in_entry.imm      = in_imm;
    in_entry.rs1_data = in_rs1_data;
    in_entry.rs2_data = in_rs2_data;
    in_entry.rs1_addr = in_rs1_addr;
    in_entry.rs2_addr = in_rs2_addr;
    in_entry.rd       = in_rd;
    in_entry.rd_wen   = in_rd_wen && (in_rd != '0);
    in_entry.ctrl     = in_ctrl;
  end

  assign wb_hit = wb_wen && (wb_rd != '0);

  // A held entry picks up a writeback to either source register.
  // rs1 and rs2 are checked separately, so both update when they name
  // the same register.
  function automatic entry_t refresh(input entry_t e);
    entry_t r;
    r = e;
    if (wb_hit && (wb_rd == e.rs1_addr)) r.rs1_data = wb_data;
    if (wb_hit && (wb_rd == e.rs2_addr)) r.rs2_data = wb_data;
    return r;
  endfunction

`ifdef ID_EX_SKID_EN
  entry_t skid_q;
  logic   skid_valid_q;
  logic   in_ready_q;

  assign in_ready = in_ready_q;
  assign accept   = in_valid && in_ready_q;

  // Output entry plus skid entry. The skid entry fills only while the
  // output entry is stalled. When the output frees up, the skid entry
  // moves forward on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_q        <= refresh(skid_q);
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        out_q       <= in_entry;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else begin
      out_q <= refresh(out_q);
      if (accept) begin
        skid_q       <= in_entry;
        skid_valid_q <= 1'b1;
        in_ready_q   <= 1'b0;
      end else if (skid_valid_q) begin
        skid_q <= refresh(skid_q);
      end
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Single entry. An accept replaces the entry, including an entry that
  // issues on the same edge, so back-to-back instructions leave no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= in_entry;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (out_valid_q) out_q <= refresh(out_q);
    end
  end
`endif

  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_imm      = out_q.imm;
  assign out_rs1_data = out_q.rs1_data;
  assign out_rs2_data = out_q.rs2_data;
  assign out_rs1_addr = out_q.rs1_addr;
  assign out_rs2_addr = out_q.rs2_addr;
  assign out_rd       = out_q.rd;
  assign out_rd_wen   = out_q.rd_wen;
  assign out_ctrl     = out_q.ctrl;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: table-driven vectors plus
// hand-written multi-cycle sequences. The sequences cover stall, reset
// and the skid entry.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
  logic        in_rd_wen;
  logic [15:0] in_ctrl;
  logic        flush;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_imm, out_rs1_data, out_rs2_data;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd;
  logic        out_rd_wen;
  logic [15:0] out_ctrl;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_pipe #(.CTRL_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_ctrl(in_ctrl),
    .flush(flush),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_ctrl(out_ctrl)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rdw;
    logic [4:0]  rs1a;
    logic [31:0] rs1d;
    logic [4:0]  rs2a;
    logic [31:0] rs2d;
    logic        ordy;
    logic        fl;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        ev;
    logic [31:0] epc;
    logic [4:0]  erd;
    logic        ewen;
    logic [31:0] ers1;
    logic [31:0] ers2;
  } vec_t;

  vec_t vecs[$];

  // imm and ctrl are derived from the pc, so each vector also checks
  // that they are carried across intact.
  function automatic logic [31:0] imm_of(input logic [31:0] pc);
    return pc + 32'h1000;
  endfunction
  function automatic logic [15:0] ctrl_of(input logic [31:0] pc);
    return pc[15:0] ^ 16'h5A5A;
  endfunction

  function automatic vec_t mk(
    input logic iv, input logic [31:0] pc, input logic [4:0] rd, input logic rdw,
    input logic [4:0] rs1a, input logic [31:0] rs1d,
    input logic [4:0] rs2a, input logic [31:0] rs2d,
    input logic ordy, input logic fl,
    input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
    input logic ev, input logic [31:0] epc, input logic [4:0] erd, input logic ewen,
    input logic [31:0] ers1, input logic [31:0] ers2);
    vec_t v;
    v.iv = iv; v.pc = pc; v.rd = rd; v.rdw = rdw;
    v.rs1a = rs1a; v.rs1d = rs1d; v.rs2a = rs2a; v.rs2d = rs2d;
    v.ordy = ordy; v.fl = fl; v.wbw = wbw; v.wbrd = wbrd; v.wbd = wbd;
    v.ev = ev; v.epc = epc; v.erd = erd; v.ewen = ewen; v.ers1 = ers1; v.ers2 = ers2;
    return v;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic idle();
    in_valid = 0; in_pc = 0; in_imm = 0; in_rs1_data = 0; in_rs2_data = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd = 0; in_rd_wen = 0; in_ctrl = 0;
    flush = 0; wb_wen = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rd,
                       input logic [4:0] rs1a, input logic [31:0] rs1d);
    in_valid = 1; in_pc = pc; in_imm = imm_of(pc); in_ctrl = ctrl_of(pc);
    in_rd = rd; in_rd_wen = 1; in_rs1_addr = rs1a; in_rs1_data = rs1d;
    in_rs2_addr = 0; in_rs2_data = 0;
  endtask

  task automatic apply(input vec_t v);
    in_valid = v.iv; in_pc = v.pc; in_imm = imm_of(v.pc); in_ctrl = ctrl_of(v.pc);
    in_rd = v.rd; in_rd_wen = v.rdw;
    in_rs1_addr = v.rs1a; in_rs1_data = v.rs1d;
    in_rs2_addr = v.rs2a; in_rs2_data = v.rs2d;
    out_ready = v.ordy; flush = v.fl;
    wb_wen = v.wbw; wb_rd = v.wbrd; wb_data = v.wbd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_out_rs1_data", out_rs1_data, 32'd0);
    chk("reset_out_ctrl", {16'd0, out_ctrl}, 32'd0);
    chk("reset_out_rd_wen", {31'd0, out_rd_wen}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    //         iv pc        rd rdw rs1a rs1d     rs2a rs2d     ordy fl wbw wbrd wbd        ev epc       erd ewen ers1     ers2
    vecs.push_back(mk(1, 32'h100, 5, 1, 0, 0,        0, 0,        1, 0, 0, 0, 0,          1, 32'h100, 5, 1, 0,        0));
    vecs.push_back(mk(1, 32'h0,   1, 1, 0, 0,        0, 0,        1, 0, 0, 0, 0,          1, 32'h0,   1, 1, 0,        0));
    vecs.push_back(mk(1, 32'h4,   2, 1, 0, 0,        0, 0,        1, 0, 0, 0, 0,          1, 32'h4,   2, 1, 0,        0));
    vecs.push_back(mk(1, 32'h8,   3, 1, 0, 0,        0, 0,        1, 0, 0, 0, 0,          1, 32'h8,   3, 1, 0,        0));
    vecs.push_back(mk(1, 32'hC,   4, 1, 0, 0,        0, 0,        1, 0, 0, 0, 0,          1, 32'hC,   4, 1, 0,        0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 0, 0,        0, 0,        1, 0, 0, 0, 0,          0, 32'h0,   0, 0, 0,        0));
    // load while stalled downstream, then refresh both operands from one writeback
    vecs.push_back(mk(1, 32'h20,  7, 1, 3, 32'h11,   3, 32'h22,   0, 0, 0, 0, 0,          1, 32'h20,  7, 1, 32'h11,   32'h22));
    vecs.push_back(mk(0, 32'h0,   0, 0, 0, 0,        0, 0,        0, 0, 1, 3, 32'hDEAD,   1, 32'h20,  7, 1, 32'hDEAD, 32'hDEAD));
    vecs.push_back(mk(0, 32'h0,   0, 0, 0, 0,        0, 0,        0, 0, 1, 0, 32'hBEEF,   1, 32'h20,  7, 1, 32'hDEAD, 32'hDEAD));
    vecs.push_back(mk(0, 32'h0,   0, 0, 0, 0,        0, 0,        0, 0, 1, 4, 32'h55,     1, 32'h20,  7, 1, 32'hDEAD, 32'hDEAD));
    // flush while full and offering: both vanish
    vecs.push_back(mk(1, 32'h40,  9, 1, 0, 0,        0, 0,        0, 1, 0, 0, 0,          0, 32'h0,   0, 0, 0,        0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 0, 0,        0, 0,        1, 0, 0, 0, 0,          0, 32'h0,   0, 0, 0,        0));
    // rd = x0 suppresses the write enable
    vecs.push_back(mk(1, 32'h50,  0, 1, 0, 0,        0, 0,        1, 0, 0, 0, 0,          1, 32'h50,  0, 0, 0,        0));
    vecs.push_back(mk(1, 32'h54,  6, 0, 0, 0,        0, 0,        1, 0, 0, 0, 0,          1, 32'h54,  6, 0, 0,        0));
    // load while a writeback to the same register is on the bus: in_rs1_data wins
    vecs.push_back(mk(1, 32'h60,  2, 1, 3, 32'h77,   0, 0,        1, 0, 1, 3, 32'h99,     1, 32'h60,  2, 1, 32'h77,   0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 0, 0,        0, 0,        1, 0, 0, 0, 0,          0, 32'h0,   0, 0, 0,        0));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      step();
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].epc);
        chk($sformatf("v%0d_out_imm", i), out_imm, imm_of(vecs[i].epc));
        chk($sformatf("v%0d_out_ctrl", i), {16'd0, out_ctrl}, {16'd0, ctrl_of(vecs[i].epc)});
        chk($sformatf("v%0d_out_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].erd});
        chk($sformatf("v%0d_out_rd_wen", i), {31'd0, out_rd_wen}, {31'd0, vecs[i].ewen});
        chk($sformatf("v%0d_out_rs1_data", i), out_rs1_data, vecs[i].ers1);
        chk($sformatf("v%0d_out_rs2_data", i), out_rs2_data, vecs[i].ers2);
      end
    end

    // Reset asserted mid-stall discards the held entry
    idle();
    offer(32'h400, 8, 0, 0);
    step();
    chk("rst_stall_loaded", out_pc, 32'h400);
    idle();
    reset = 1;
    step();
    reset = 0;
    chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_pc", out_pc, 32'd0);
    chk("rst_stall_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1;
    step();
    chk("rst_stall_no_issue", {31'd0, out_valid}, 32'd0);

`ifdef ID_EX_SKID_EN
    // Two offers under backpressure: the second goes to the skid entry
    idle();
    offer(32'h200, 10, 0, 0);
    step();
    chk("skid_a_valid", {31'd0, out_valid}, 32'd1);
    chk("skid_a_in_ready", {31'd0, in_ready}, 32'd1);
    offer(32'h204, 11, 8, 32'h1);
    step();
    chk("skid_b_in_ready", {31'd0, in_ready}, 32'd0);
    chk("skid_b_out_pc", out_pc, 32'h200);
    offer(32'h208, 12, 0, 0);
    wb_wen = 1; wb_rd = 8; wb_data = 32'hABC;
    step();
    chk("skid_c_out_pc", out_pc, 32'h200);
    chk("skid_c_in_ready", {31'd0, in_ready}, 32'd0);
    idle();
    out_ready = 1;
    step();
    chk("skid_issue1_valid", {31'd0, out_valid}, 32'd1);
    chk("skid_issue1_pc", out_pc, 32'h204);
    chk("skid_issue1_rs1", out_rs1_data, 32'hABC);
    chk("skid_issue1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("skid_drained", {31'd0, out_valid}, 32'd0);
`else
    // Stall blocks the offer; releasing out_ready accepts it with no bubble
    idle();
    offer(32'h300, 13, 0, 0);
    step();
    offer(32'h304, 14, 0, 0);
    #1;
    chk("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    chk("stall_hold_pc", out_pc, 32'h300);
    out_ready = 1;
    #1;
    chk("stall_in_ready_comb", {31'd0, in_ready}, 32'd1);
    step();
    chk("replace_valid", {31'd0, out_valid}, 32'd1);
    chk("replace_pc", out_pc, 32'h304);
    idle();
    out_ready = 1;
    step();
    chk("replace_drained", {31'd0, out_valid}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter CTRL_W, default 16, width of opaque decoded-control bundle passed through unchanged.
REQ-002 XLEN (32) and REG_ADDR_WIDTH (5) SHALL be taken from riscv_pkg.
REQ-003 Clock clk, rising-edge; reset reset, synchronous, active-high.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  decode presents an instruction.
REQ-007 in_ready  out  1  block accepts the instruction this cycle.
REQ-008 in_pc, in_imm, in_rs1_data, in_rs2_data  in  XLEN each  decoded PC, immediate, register-file read data.
REQ-009 in_rs1_addr, in_rs2_addr, in_rd  in  REG_ADDR_WIDTH each  source/destination register indices.
REQ-010 in_rd_wen  in  1; in_ctrl  in  CTRL_W  destination write enable; control bundle.
REQ-011 flush  in  1  discard all held and incoming instructions.
REQ-012 wb_wen  in  1; wb_rd  in  REG_ADDR_WIDTH; wb_data  in  XLEN  writeback port, same signals driving the register-file write port.
REQ-013 out_valid  out  1; out_ready  in  1  execute-side handshake.
REQ-014 out_pc, out_imm, out_rs1_data, out_rs2_data  out  XLEN; out_rs1_addr, out_rs2_addr, out_rd  out  REG_ADDR_WIDTH; out_rd_wen  out  1; out_ctrl  out  CTRL_W  registered copies of the in_* fields.

Function
REQ-015 Transfer occurs on in_valid&&in_ready (accept) and out_valid&&out_ready (issue); latency accept-to-out_valid SHALL be exactly 1 cycle when the block is empty.
REQ-016 Instructions SHALL issue in acceptance order; none duplicated or dropped except by flush.
REQ-017 While out_valid&&!out_ready, all out_* fields SHALL remain stable, except out_rs1_data/out_rs2_data as permitted by REQ-019.
REQ-018 out_rd_wen SHALL be forced 0 when captured in_rd==0.
REQ-019 Held-operand refresh: for every held valid entry, if wb_wen && wb_rd!=0 && wb_rd==entry rs1_addr (resp. rs2_addr), the entry's rs1_data (resp. rs2_data) SHALL take wb_data at the next edge; rs1 and rs2 matching the same wb_rd SHALL both update.
REQ-020 An entry being loaded from in_* in a cycle SHALL take in_rs*_data unmodified (register file already bypasses same-cycle writes).
REQ-021 flush SHALL, at the next edge, clear all entry valid bits; an instruction offered in the flush cycle SHALL be discarded even if in_ready=1; flush has priority over accept, issue and refresh.
REQ-022 Payload registers need not clear on flush; only valid bits.
REQ-023 Simultaneous accept and issue on a full single-entry stage SHALL replace the entry with no bubble.

Reset
REQ-024 On reset all valid bits SHALL clear; out_valid=0 the following cycle.
REQ-025 All out_* payload fields SHALL reset to 0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-027 Reset asserted mid-stall SHALL discard held entries; no issue occurs in the reset cycle's aftermath.

Configuration
REQ-028 Macro ID_EX_SKID_EN selects the buffering structure.
REQ-029 Without ID_EX_SKID_EN: single entry; in_ready = !out_valid || out_ready (combinational from out_ready).
REQ-030 With ID_EX_SKID_EN: output entry plus one skid entry; in_ready SHALL be a flop output equal to "skid entry empty", with no combinational path from out_ready.
REQ-031 With ID_EX_SKID_EN: an accept while output is valid and not issuing SHALL fill the skid entry; on next issue the skid entry SHALL move to output in the same edge; full-rate (1/cycle) throughput SHALL be sustained when out_ready=1.
REQ-032 REQ-019 refresh SHALL apply to the skid entry as well as the output entry.

Verification
REQ-033 Reset, then in_valid=1 in_pc=0x100 in_rd=5, out_ready=1 -> next cycle out_valid=1 out_pc=0x100 out_rd=5 out_rd_wen=1.
REQ-034 Stream pc 0x0,0x4,0x8,0xC with out_ready=1 -> four consecutive out_valid cycles, same order, no bubbles (both configurations).
REQ-035 Hold out_ready=0 with entry rs1_addr=3 rs1_data=0x11; drive wb_wen=1 wb_rd=3 wb_data=0xDEAD -> out_rs1_data=0xDEAD next cycle, other fields unchanged; wb_rd=0 -> no change.
REQ-036 Full with out_ready=0, assert flush with in_valid=1 -> next cycle out_valid=0; flushed and offered instructions never appear on out_*.
REQ-037 ID_EX_SKID_EN: out_ready=0, offer two instructions -> both accepted, in_ready=0 on third cycle; release out_ready -> both issue in order on consecutive cycles.
REQ-038 in_rd=0 in_rd_wen=1 -> out_rd_wen=0.
